// File: rtl/mlp_layer_scheduler.sv
// Sequencer for a chain of fc_layer stages: issues start/func pulses and tracks input-buffer occupancy.
// Optional macro MLP_SCHED_STALL_CNT_EN adds per-layer WAIT_DST stall counters on o_stall_cycles.
module mlp_layer_scheduler #(
    parameter int NUM_LAYERS     = 5,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic [NUM_LAYERS-1:0]    o_start,
    input  logic [NUM_LAYERS-1:0]    i_cim_busy,
    output logic [NUM_LAYERS-1:0]    o_func_start,
    input  logic [NUM_LAYERS-1:0]    i_busy,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [NUM_LAYERS-1:0]    o_error,
    output logic [CNT_WIDTH-1:0]     o_frames_done
`ifdef MLP_SCHED_STALL_CNT_EN
    ,
    output logic [NUM_LAYERS*16-1:0] o_stall_cycles
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_MVM, S_WAIT_DST, S_FUNC, S_DRAIN
    } state_t;

    logic [NUM_LAYERS-1:0] ibuf_full_q, ibuf_full_d;
    logic [NUM_LAYERS-1:0] error_q, error_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]  frames_q, frames_d;
    logic [NUM_LAYERS-1:0] mvm_exit, drain_exit, mvm_tmo, drain_tmo;
    logic [NUM_LAYERS-1:0] start_pulse, func_pulse;
    logic                  in_fire, out_fire;

    assign in_fire  = i_in_valid & ~ibuf_full_q[0];
    assign out_fire = out_valid_q & i_out_ready;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            state_t        state_q, state_d;
            logic          seen_q, seen_d;
            logic [TW-1:0] timer_q, timer_d;
            logic          dst_free;
            logic          ibuf_set;
            logic          mvm_exit_l, drain_exit_l, mvm_tmo_l, drain_tmo_l;

            if (gi == NUM_LAYERS - 1) begin : g_last
                assign dst_free = ~out_valid_q;
            end else begin : g_mid
                assign dst_free = ~ibuf_full_q[gi+1];
            end

            if (gi == 0) begin : g_first_set
                assign ibuf_set = in_fire;
            end else begin : g_chain_set
                assign ibuf_set = drain_exit[gi-1];
            end

            always_comb begin
                state_d      = state_q;
                seen_d       = seen_q;
                timer_d      = timer_q;
                mvm_exit_l   = 1'b0;
                drain_exit_l = 1'b0;
                mvm_tmo_l    = 1'b0;
                drain_tmo_l  = 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (ibuf_full_q[gi]) state_d = S_START;
                    end
                    S_START: begin
                        state_d = S_MVM;
                        seen_d  = 1'b0;
                        timer_d = '0;
                    end
                    S_MVM: begin
                        seen_d  = seen_q | i_cim_busy[gi];
                        timer_d = timer_q + 1'b1;
                        // A genuine completion wins over a timeout landing in the same cycle
                        if (seen_q && !i_cim_busy[gi]) begin
                            mvm_exit_l = 1'b1;
                            state_d    = S_WAIT_DST;
                        end else if (timer_q == TMO_LAST) begin
                            mvm_tmo_l = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                    S_WAIT_DST: begin
                        if (dst_free) state_d = S_FUNC;
                    end
                    S_FUNC: begin
                        state_d = S_DRAIN;
                        seen_d  = 1'b0;
                        timer_d = '0;
                    end
                    S_DRAIN: begin
                        seen_d  = seen_q | i_busy[gi];
                        timer_d = timer_q + 1'b1;
                        if (seen_q && !i_busy[gi]) begin
                            drain_exit_l = 1'b1;
                            state_d      = S_IDLE;
                        end else if (timer_q == TMO_LAST) begin
                            drain_tmo_l = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= S_IDLE;
                    seen_q  <= 1'b0;
                    timer_q <= '0;
                end else begin
                    state_q <= state_d;
                    seen_q  <= seen_d;
                    timer_q <= timer_d;
                end
            end

            assign mvm_exit[gi]    = mvm_exit_l;
            assign drain_exit[gi]  = drain_exit_l;
            assign mvm_tmo[gi]     = mvm_tmo_l;
            assign drain_tmo[gi]   = drain_tmo_l;
            assign start_pulse[gi] = (state_q == S_START);
            assign func_pulse[gi]  = (state_q == S_FUNC);

            // A DRAIN timeout must not touch the buffer: it was released at MVM exit
            // and may already hold the next frame.
            assign ibuf_full_d[gi] = ibuf_set ? 1'b1 :
                                     ((mvm_exit_l | mvm_tmo_l) ? 1'b0 : ibuf_full_q[gi]);
            assign error_d[gi]     = error_q[gi] | mvm_tmo_l | drain_tmo_l;

`ifdef MLP_SCHED_STALL_CNT_EN
            logic [15:0] stall_q, stall_d;

            always_comb begin
                stall_d = stall_q;
                if (state_q == S_WAIT_DST && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) stall_q <= '0;
                else      stall_q <= stall_d;
            end

            assign o_stall_cycles[gi*16 +: 16] = stall_q;
`endif
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        frames_d    = frames_q;
        if (drain_exit[NUM_LAYERS-1]) out_valid_d = 1'b1;
        else if (out_fire)            out_valid_d = 1'b0;
        if (out_fire) frames_d = frames_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ibuf_full_q <= '0;
            error_q     <= '0;
            out_valid_q <= 1'b0;
            frames_q    <= '0;
        end else begin
            ibuf_full_q <= ibuf_full_d;
            error_q     <= error_d;
            out_valid_q <= out_valid_d;
            frames_q    <= frames_d;
        end
    end

    assign o_in_ready    = ~ibuf_full_q[0];
    assign o_start       = start_pulse;
    assign o_func_start  = func_pulse;
    assign o_out_valid   = out_valid_q;
    assign o_error       = error_q;
    assign o_frames_done = frames_q;

endmodule
